// File: rtl/pad_io_ctrl.sv
// Core-side controller for one bidirectional GPIO pad: synchronised and filtered
// input with edge strobes, plus a direction handshake with turnaround gaps.
// Optional drive-conflict monitor: define PAD_IO_CONFLICT_CHECK_EN.
module pad_io_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int TURN_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic dir_valid,
  input  logic dir_out,
  output logic dir_ready,
  input  logic dout,
  input  logic pull_en,
  output logic din,
  output logic din_rise,
  output logic din_fall,
  output logic busy,
  output logic conflict,
  output logic pad_i,
  output logic pad_oen,
  output logic pad_ren,
  input  logic pad_c
);

  typedef enum logic [1:0] {
    IN_IDLE     = 2'd0,
    TURN_TO_OUT = 2'd1,
    OUT_DRIVE   = 2'd2,
    TURN_TO_IN  = 2'd3
  } state_t;

  localparam logic [3:0] TURN_LOAD = 4'(TURN_CYCLES);
  localparam logic [3:0] FILT_LAST = 4'(FILT_LEN - 1);

  state_t                 state;
  state_t                 state_nxt;
  logic [3:0]             turn_cnt;
  logic [3:0]             turn_cnt_nxt;
  logic                   rdy_nxt;
  logic                   accept;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_out;
  logic [3:0]             filt_cnt;
  logic                   filt_diff;
  logic                   filt_hit;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec4(input logic [3:0] v);
    return (v == 4'h0) ? v : v - 4'd1;
  endfunction

  assign accept    = dir_valid & dir_ready;
  assign sync_out  = sync_p[SYNC_STAGES-1];
  assign filt_diff = (sync_out != din);
  assign filt_hit  = (state == IN_IDLE) && filt_diff && (filt_cnt >= FILT_LAST);

  always_comb begin
    state_nxt    = state;
    turn_cnt_nxt = turn_cnt;
    case (state)
      IN_IDLE: begin
        if (accept && dir_out) begin
          state_nxt    = TURN_TO_OUT;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      TURN_TO_OUT: begin
        turn_cnt_nxt = sat_dec4(turn_cnt);
        if (turn_cnt <= 4'd1) state_nxt = OUT_DRIVE;
      end
      OUT_DRIVE: begin
        if (accept && !dir_out) begin
          state_nxt    = TURN_TO_IN;
          turn_cnt_nxt = TURN_LOAD;
        end
      end
      TURN_TO_IN: begin
        turn_cnt_nxt = sat_dec4(turn_cnt);
        if (turn_cnt <= 4'd1) state_nxt = IN_IDLE;
      end
      default: begin
        state_nxt    = IN_IDLE;
        turn_cnt_nxt = 4'd0;
      end
    endcase
    rdy_nxt = (state_nxt == IN_IDLE) || (state_nxt == OUT_DRIVE);
  end

  // Stage p0: state, pad controls and input filter, all registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IN_IDLE;
      turn_cnt  <= 4'd0;
      sync_p    <= '1;
      filt_cnt  <= 4'd0;
      din       <= 1'b1;
      din_rise  <= 1'b0;
      din_fall  <= 1'b0;
      dir_ready <= 1'b1;
      busy      <= 1'b0;
      pad_oen   <= 1'b1;
      pad_i     <= 1'b0;
      pad_ren   <= 1'b0;
    end else begin
      state     <= state_nxt;
      turn_cnt  <= turn_cnt_nxt;
      sync_p    <= {sync_p[SYNC_STAGES-2:0], pad_c};
      dir_ready <= rdy_nxt;
      busy      <= ~rdy_nxt;
      pad_oen   <= (state_nxt != OUT_DRIVE);
      pad_ren   <= ((state_nxt == TURN_TO_OUT) || (state_nxt == OUT_DRIVE)) ? 1'b1 : ~pull_en;
      // Also load on the entry edge so valid data is present when pad_oen first falls.
      if ((state == OUT_DRIVE) || (state_nxt == OUT_DRIVE)) pad_i <= dout;
      din_rise  <= filt_hit & ~din;
      din_fall  <= filt_hit & din;
      if (state == IN_IDLE) begin
        if (filt_hit) begin
          din      <= ~din;
          filt_cnt <= 4'd0;
        end else if (filt_diff) begin
          filt_cnt <= sat_inc4(filt_cnt);
        end else begin
          filt_cnt <= 4'd0;
        end
      end else begin
        filt_cnt <= 4'd0;
        // Whatever the line settled to during the gap becomes the new level silently.
        if ((state == TURN_TO_IN) && (state_nxt == IN_IDLE)) din <= sync_out;
      end
    end
  end

`ifdef PAD_IO_CONFLICT_CHECK_EN
  logic [SYNC_STAGES:0] pad_i_dly_p1;
  logic [SYNC_STAGES:0] vld_p1;
  logic                 cmp_mis;

  assign cmp_mis = (state == OUT_DRIVE) && vld_p1[SYNC_STAGES] &&
                   (sync_out != pad_i_dly_p1[SYNC_STAGES]);

  // Stage p1: driven value delayed to line up with the synchronised pad echo
  always_ff @(posedge clk) begin
    if (state == OUT_DRIVE) pad_i_dly_p1 <= {pad_i_dly_p1[SYNC_STAGES-1:0], pad_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= '0;
      conflict <= 1'b0;
    end else begin
      vld_p1 <= (state == OUT_DRIVE) ? {vld_p1[SYNC_STAGES-1:0], 1'b1} : '0;
      if (cmp_mis) conflict <= 1'b1;
    end
  end
`else
  assign conflict = 1'b0;
`endif

endmodule

// File: tb/tb_pad_io_ctrl.sv
// Scoreboard bench for pad_io_ctrl: stimulus schedules expected levels and edge
// strobes; a negedge monitor compares them as the DUT presents them.
module tb_pad_io_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic dir_valid, dir_out, dir_ready, dout, pull_en;
  logic din, din_rise, din_fall, busy, conflict;
  logic pad_i, pad_oen, pad_ren, pad_c;

  logic ext_lvl, force_c, force_val, pad_i_q;

  int cyc = 0;
  int errors = 0;
  int checks = 0;

  localparam int S_DIN = 0, S_OEN = 1, S_REN = 2, S_PADI = 3, S_RDY = 4,
                 S_BUSY = 5, S_CONF = 6, S_RISE = 7, S_FALL = 8;

`ifdef PAD_IO_CONFLICT_CHECK_EN
  localparam int EXP_CONF = 1;
`else
  localparam int EXP_CONF = 0;
`endif

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } chk_t;

  typedef struct {
    int cyc;
    bit rise;
  } ev_t;

  chk_t chkq[$];
  ev_t  evq[$];

  pad_io_ctrl #(.SYNC_STAGES(2), .FILT_LEN(4), .TURN_CYCLES(3)) dut (
    .clk(clk), .rst(rst),
    .dir_valid(dir_valid), .dir_out(dir_out), .dir_ready(dir_ready),
    .dout(dout), .pull_en(pull_en),
    .din(din), .din_rise(din_rise), .din_fall(din_fall),
    .busy(busy), .conflict(conflict),
    .pad_i(pad_i), .pad_oen(pad_oen), .pad_ren(pad_ren), .pad_c(pad_c)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Pad model: echoes the driven value one cycle later, or an external level when released.
  always @(posedge clk) pad_i_q <= pad_i;
  assign pad_c = pad_oen ? ext_lvl : (force_c ? force_val : pad_i_q);

  function automatic int get_sig(int s);
    case (s)
      S_DIN:   return int'(din);
      S_OEN:   return int'(pad_oen);
      S_REN:   return int'(pad_ren);
      S_PADI:  return int'(pad_i);
      S_RDY:   return int'(dir_ready);
      S_BUSY:  return int'(busy);
      S_CONF:  return int'(conflict);
      S_RISE:  return int'(din_rise);
      S_FALL:  return int'(din_fall);
      default: return -1;
    endcase
  endfunction

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(int dly, int sig, int val, string name);
    chkq.push_back('{cyc + dly, sig, val, name});
  endtask

  task automatic expect_ev(int dly, bit rise);
    evq.push_back('{cyc + dly, rise});
  endtask

  // Monitor: scheduled level checks plus a pop per observed strobe.
  always @(negedge clk) begin
    for (int i = chkq.size() - 1; i >= 0; i--) begin
      if (chkq[i].cyc <= cyc) begin
        checks++;
        if (chkq[i].cyc != cyc || get_sig(chkq[i].sig) != chkq[i].val) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0d want %0d (due cyc %0d)", chkq[i].name, cyc,
                   get_sig(chkq[i].sig), chkq[i].val, chkq[i].cyc);
        end
        chkq.delete(i);
      end
    end
    if (din_rise || din_fall) begin
      checks++;
      if (evq.size() == 0) begin
        errors++;
        $display("FAIL strobe @cyc %0d: got rise=%0b fall=%0b want none", cyc, din_rise, din_fall);
      end else begin
        ev_t e;
        e = evq.pop_front();
        if (e.cyc != cyc || din_rise != e.rise || din_fall != !e.rise) begin
          errors++;
          $display("FAIL strobe @cyc %0d: got rise=%0b fall=%0b want rise=%0b at cyc %0d",
                   cyc, din_rise, din_fall, e.rise, e.cyc);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; dir_valid = 1'b0; dir_out = 1'b0; dout = 1'b0; pull_en = 1'b1;
    ext_lvl = 1'b1; force_c = 1'b0; force_val = 1'b0;
    step(3);
    expect_at(0, S_OEN, 1, "rst_oen");   expect_at(0, S_REN, 0, "rst_ren");
    expect_at(0, S_DIN, 1, "rst_din");   expect_at(0, S_RDY, 1, "rst_rdy");
    expect_at(0, S_BUSY, 0, "rst_busy"); expect_at(0, S_CONF, 0, "rst_conf");
    expect_at(0, S_RISE, 0, "rst_rise"); expect_at(0, S_FALL, 0, "rst_fall");
    expect_at(0, S_PADI, 0, "rst_padi");
    rst = 1'b0;
    step(4);

    // Held low level: sync + filter latency of 6 cycles
    ext_lvl = 1'b0;
    expect_at(5, S_DIN, 1, "fall_pre"); expect_at(6, S_DIN, 0, "fall_din"); expect_ev(6, 1'b0);
    step(10);

    // 3-cycle glitch is rejected
    ext_lvl = 1'b1; step(3); ext_lvl = 1'b0;
    expect_at(8, S_DIN, 0, "glitch_din");
    step(12);

    ext_lvl = 1'b1;
    expect_at(5, S_DIN, 0, "rise_pre"); expect_at(6, S_DIN, 1, "rise_din"); expect_ev(6, 1'b1);
    step(10);

    // Input -> output turnaround
    dir_valid = 1'b1; dir_out = 1'b1; dout = 1'b1;
    expect_at(0, S_REN, 0, "to_out_ren0"); expect_at(1, S_REN, 1, "to_out_ren1");
    for (int k = 1; k <= 3; k++) begin
      expect_at(k, S_BUSY, 1, "to_out_busy"); expect_at(k, S_RDY, 0, "to_out_rdy");
    end
    expect_at(4, S_BUSY, 0, "to_out_busy_end"); expect_at(4, S_RDY, 1, "to_out_rdy_end");
    expect_at(3, S_OEN, 1, "to_out_oen_gap");   expect_at(4, S_OEN, 0, "to_out_oen_drive");
    expect_at(4, S_PADI, 1, "to_out_padi");
    step(1); dir_valid = 1'b0; step(4);
    expect_at(0, S_PADI, 1, "dout_a");
    dout = 1'b0; expect_at(1, S_PADI, 0, "dout_b"); step(1);
    dout = 1'b1; expect_at(1, S_PADI, 1, "dout_c"); step(1);
    dout = 1'b0; expect_at(1, S_PADI, 0, "dout_d"); step(1);
    expect_at(0, S_DIN, 1, "out_din_frozen");
    dout = 1'b1; step(1);

    // Same-direction request is a no-op
    dir_valid = 1'b1; dir_out = 1'b1;
    expect_at(1, S_BUSY, 0, "noop_busy"); expect_at(1, S_OEN, 0, "noop_oen");
    expect_at(1, S_RDY, 1, "noop_rdy");
    step(1); dir_valid = 1'b0; step(2);

    // Output -> input: din reloads from the released line without a strobe
    ext_lvl = 1'b0;
    dir_valid = 1'b1; dir_out = 1'b0;
    expect_at(0, S_OEN, 0, "to_in_oen0"); expect_at(1, S_OEN, 1, "to_in_oen1");
    expect_at(0, S_REN, 1, "to_in_ren1"); expect_at(1, S_REN, 0, "to_in_ren0");
    for (int k = 1; k <= 3; k++) expect_at(k, S_RDY, 0, "to_in_rdy");
    expect_at(4, S_RDY, 1, "to_in_rdy_end");
    expect_at(3, S_DIN, 1, "to_in_din_old"); expect_at(4, S_DIN, 0, "to_in_din_reload");
    expect_at(10, S_DIN, 0, "to_in_din_hold");
    step(1); dir_valid = 1'b0; step(12);

    ext_lvl = 1'b1;
    expect_at(6, S_DIN, 1, "rise2_din"); expect_ev(6, 1'b1);
    step(10);

    // Reset in the second TURN_TO_OUT cycle
    pull_en = 1'b0; step(2);
    expect_at(0, S_REN, 1, "pull_off_ren");
    dir_valid = 1'b1; dir_out = 1'b1;
    step(1); dir_valid = 1'b0;
    expect_at(0, S_OEN, 1, "mid_oen_a"); expect_at(0, S_BUSY, 1, "mid_busy");
    step(1);
    rst = 1'b1;
    expect_at(0, S_OEN, 1, "mid_oen_b");
    expect_at(1, S_OEN, 1, "mid_rst_oen");  expect_at(1, S_BUSY, 0, "mid_rst_busy");
    expect_at(1, S_RDY, 1, "mid_rst_rdy");  expect_at(1, S_REN, 0, "mid_rst_ren");
    expect_at(1, S_DIN, 1, "mid_rst_din");  expect_at(1, S_PADI, 0, "mid_rst_padi");
    expect_at(1, S_CONF, 0, "mid_rst_conf");
    step(1);
    rst = 1'b0;
    expect_at(1, S_OEN, 1, "post_rst_oen"); expect_at(1, S_REN, 1, "post_rst_ren");
    expect_at(2, S_BUSY, 0, "post_rst_busy");
    step(5);
    pull_en = 1'b1;

    // Drive conflict: pad held low while driving high
    force_c = 1'b1; force_val = 1'b0;
    dir_valid = 1'b1; dir_out = 1'b1; dout = 1'b1;
    step(1); dir_valid = 1'b0; step(3);
    expect_at(3, S_CONF, 0, "conf_early");
    expect_at(4, S_CONF, EXP_CONF, "conf_set");
    expect_at(8, S_CONF, EXP_CONF, "conf_sticky");
    step(6); force_c = 1'b0; step(4);
    rst = 1'b1;
    expect_at(1, S_CONF, 0, "conf_rst"); expect_at(1, S_OEN, 1, "conf_rst_oen");
    step(1); rst = 1'b0; step(3);

    foreach (chkq[i]) begin
      checks++; errors++;
      $display("FAIL %s: never compared, want %0d at cyc %0d", chkq[i].name, chkq[i].val, chkq[i].cyc);
    end
    foreach (evq[i]) begin
      checks++; errors++;
      $display("FAIL strobe: got none, want rise=%0b at cyc %0d", evq[i].rise, evq[i].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
